// File: rtl/switch_conditioner_if.sv
// Pad-side bundle for the switch conditioner: raw switch/key pads in,
// clean levels, mode bit and event pulses out.
interface switch_conditioner_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic             key_raw_n;
  logic [WIDTH-1:0] sw_clean;
  logic             mode_pass;
  logic             sw_changed;
  logic             key_press;

  // pad/board side drives the raw inputs and consumes the clean outputs
  modport master (
    output sw_raw, key_raw_n,
    input  sw_clean, mode_pass, sw_changed, key_press
  );

  // conditioner side
  modport slave (
    input  sw_raw, key_raw_n,
    output sw_clean, mode_pass, sw_changed, key_press
  );
endinterface

// File: rtl/switch_conditioner.sv
// Slide-switch and mode-button conditioner: two-flop synchronisers, per-input
// debounce counters, registered change/press pulses and the pass/invert bit.
// Optional build macro SWITCH_COND_TOGGLE_EN: mode_pass toggles on each
// accepted press; without it mode_pass follows the debounced key level.
module switch_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  switch_conditioner_if.slave  bus
);

  // Lane WIDTH is the key (active-low, idles at 1); lanes below are switches.
  localparam logic [WIDTH:0]   RST_VEC = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH:0] raw;
  logic [WIDTH:0] sync1, sync2;
  logic [WIDTH:0] q;
  logic [WIDTH:0] acc;
  logic           sw_changed_r;
  logic           key_press_r;
  logic           mode_r;

  assign raw = {bus.key_raw_n, bus.sw_raw};

  // two-flop synchroniser on every pad before any other logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_VEC;
      sync2 <= RST_VEC;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i <= WIDTH; i++) begin : g_lane
    logic             ql;
    logic [CNT_W-1:0] cnt;

    // accept on the cycle the disagreement has been seen DEBOUNCE_CYCLES times
    assign acc[i] = (sync2[i] != ql) && (cnt == LAST);
    assign q[i]   = ql;

    // debounce: any agreement restarts the count, so it never passes LAST
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ql  <= RST_VEC[i];
        cnt <= '0;
      end else if (sync2[i] == ql) begin
        cnt <= '0;
      end else if (acc[i]) begin
        ql  <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // event pulses registered alongside the accepted level they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_changed_r <= 1'b0;
      key_press_r  <= 1'b0;
    end else begin
      sw_changed_r <= |acc[WIDTH-1:0];
      key_press_r  <= acc[WIDTH] & ~sync2[WIDTH];
    end
  end

`ifdef SWITCH_COND_TOGGLE_EN
  // toggle mode: flip the cycle after each accepted press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_r <= 1'b1;
    else        mode_r <= mode_r ^ key_press_r;
  end
`else
  // momentary mode: track the debounced key level in the same cycle it moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          mode_r <= 1'b1;
    else if (acc[WIDTH]) mode_r <= sync2[WIDTH];
    else                 mode_r <= q[WIDTH];
  end
`endif

  assign bus.sw_clean   = q[WIDTH-1:0];
  assign bus.mode_pass  = mode_r;
  assign bus.sw_changed = sw_changed_r;
  assign bus.key_press  = key_press_r;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with DEBOUNCE_CYCLES=4: expected
// switch/key events are queued with their due cycle and matched by a monitor.
module tb_switch_conditioner;

  localparam int W = 8;
  localparam int N = 4;
`ifdef SWITCH_COND_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [W-1:0] val;
  } sw_ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   nchk = 0, npass = 0, nfail = 0;

  sw_ev_t sw_q[$];
  int     key_q[$];
  sw_ev_t me;
  int     mk;

  switch_conditioner_if #(.WIDTH(W)) bus();

  switch_conditioner #(
    .WIDTH(W), .DEBOUNCE_CYCLES(N), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_sw(input logic [W-1:0] v);
    sw_ev_t e;
    e.cyc = cyc + N + 2;
    e.val = v;
    sw_q.push_back(e);
  endtask

  task automatic push_key();
    key_q.push_back(cyc + N + 2);
  endtask

  // scoreboard: every pulse must match the oldest queued event and its cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sw_changed) begin
        if (sw_q.size() == 0) chk("sw_changed_unexpected", bus.sw_changed, 0);
        else begin
          me = sw_q.pop_front();
          chk("sw_changed_cycle", cyc, me.cyc);
          chk("sw_clean_value", bus.sw_clean, me.val);
        end
      end
      if (bus.key_press) begin
        if (key_q.size() == 0) chk("key_press_unexpected", bus.key_press, 0);
        else begin
          mk = key_q.pop_front();
          chk("key_press_cycle", cyc, mk);
        end
      end
    end
  end

  initial begin
    // reset with everything active at the pads
    rst_n = 1'b0;
    bus.sw_raw = 8'hFF;
    bus.key_raw_n = 1'b0;
    tick(3);
    chk("rst_sw_clean", bus.sw_clean, 0);
    chk("rst_mode_pass", bus.mode_pass, 1);
    chk("rst_sw_changed", bus.sw_changed, 0);
    chk("rst_key_press", bus.key_press, 0);

    // release with inputs held: accepted on edge 6
    rst_n = 1'b1;
    push_sw(8'hFF);
    push_key();
    tick(5);
    chk("rel_edge5_sw", bus.sw_clean, 0);
    tick(1);
    chk("rel_edge6_sw", bus.sw_clean, 8'hFF);
    chk("rel_edge6_chg", bus.sw_changed, 1);
    chk("rel_edge6_mode", bus.mode_pass, TOG ? 32'd1 : 32'd0);
    tick(1);
    chk("rel_edge7_chg", bus.sw_changed, 0);
    chk("rel_edge7_mode", bus.mode_pass, 0);
    bus.key_raw_n = 1'b1;
    tick(8);
    chk("rel_release_mode", bus.mode_pass, TOG ? 32'd0 : 32'd1);

    // clean edge 00 -> A5
    bus.sw_raw = 8'h00;
    push_sw(8'h00);
    tick(8);
    bus.sw_raw = 8'hA5;
    push_sw(8'hA5);
    tick(5);
    chk("clean_edge5", bus.sw_clean, 8'h00);
    tick(1);
    chk("clean_edge6", bus.sw_clean, 8'hA5);
    chk("clean_edge6_chg", bus.sw_changed, 1);
    tick(1);
    chk("clean_edge7_chg", bus.sw_changed, 0);

    // glitch on bit 3 shorter than the debounce window
    bus.sw_raw = 8'hAD;
    tick(3);
    bus.sw_raw = 8'hA5;
    tick(8);
    chk("glitch_sw", bus.sw_clean, 8'hA5);

    // bouncing key, then held pressed
    bus.key_raw_n = 1'b0; tick(2);
    bus.key_raw_n = 1'b1; tick(2);
    bus.key_raw_n = 1'b0;
    push_key();
    tick(8);
    chk("bounce_mode", bus.mode_pass, TOG ? 32'd1 : 32'd0);
    bus.key_raw_n = 1'b1;
    tick(8);
    chk("bounce_rel_mode", bus.mode_pass, 1);

    // two clean presses
    bus.key_raw_n = 1'b0;
    push_key();
    tick(6);
    chk("press1_kp", bus.key_press, 1);
    chk("press1_mode_e6", bus.mode_pass, TOG ? 32'd1 : 32'd0);
    tick(1);
    chk("press1_kp_e7", bus.key_press, 0);
    chk("press1_mode_e7", bus.mode_pass, 0);
    bus.key_raw_n = 1'b1;
    tick(8);
    chk("press1_rel_mode", bus.mode_pass, TOG ? 32'd0 : 32'd1);
    bus.key_raw_n = 1'b0;
    push_key();
    tick(7);
    chk("press2_mode", bus.mode_pass, TOG ? 32'd1 : 32'd0);
    bus.key_raw_n = 1'b1;
    tick(8);
    chk("press2_rel_mode", bus.mode_pass, 1);

    // switch change and key press accepted in the same cycle
    bus.sw_raw = 8'h5A;
    bus.key_raw_n = 1'b0;
    push_sw(8'h5A);
    push_key();
    tick(6);
    chk("both_sw", bus.sw_clean, 8'h5A);
    chk("both_chg", bus.sw_changed, 1);
    chk("both_kp", bus.key_press, 1);
    tick(1);
    chk("both_mode", bus.mode_pass, 0);
    bus.key_raw_n = 1'b1;
    tick(8);
    chk("both_rel_mode", bus.mode_pass, TOG ? 32'd0 : 32'd1);

    // asynchronous reset in the middle of a count
    bus.sw_raw = 8'h80;
    push_sw(8'h80);
    tick(8);
    chk("pre_rst_sw", bus.sw_clean, 8'h80);
    bus.sw_raw = 8'h01;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sw", bus.sw_clean, 0);
    chk("midrst_mode", bus.mode_pass, 1);
    chk("midrst_chg", bus.sw_changed, 0);
    #2 rst_n = 1'b1;
    push_sw(8'h01);
    tick(5);
    chk("midrst_edge5", bus.sw_clean, 8'h00);
    tick(1);
    chk("midrst_edge6", bus.sw_clean, 8'h01);

    tick(3);
    chk("sw_queue_drained", sw_q.size(), 0);
    chk("key_queue_drained", key_q.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input-side conditioner for the board's slide switches and the mode push button.
- Synchronises and debounces raw pad inputs and produces clean switch levels plus the pass/invert mode bit.
- Its outputs feed the switch-to-LED display path directly: sw_clean drives the 8-bit data input, mode_pass drives the pass/invert select.
- All outputs are registered and glitch-free.

Parameters:
- WIDTH, 8, number of slide switches conditioned.
- DEBOUNCE_CYCLES, 500000, clocks a synchronised input must hold a new level before it is accepted (10 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 19, width of each per-input debounce counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw slide-switch pads; asynchronous to clk.
- key_raw_n  input  1  raw push-button pad; active-low (0 = pressed); asynchronous.
- sw_clean  output  WIDTH  debounced switch levels.
- mode_pass  output  1  1 = pass-through, 0 = invert; drives the display path's select.
- sw_changed  output  1  one-cycle pulse when any sw_clean bit changes.
- key_press  output  1  one-cycle pulse on each accepted button press.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately):
  - sw_clean = 0, mode_pass = 1, sw_changed = 0, key_press = 0.
  - Switch synchronisers = 0, key synchroniser = 1 (released), debounced key = 1, all counters = 0.
- Synchroniser: each of the WIDTH+1 inputs passes through two flops before any other logic.
- Debounce (identical per input, independent counters). Each cycle, compare synchronised value s with accepted value q:
  - s == q: counter cleared to 0.
  - s != q and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s != q and counter == DEBOUNCE_CYCLES-1: q <= s, counter <= 0.
- Latency: a raw change held steady is visible on sw_clean exactly DEBOUNCE_CYCLES+2 rising edges after it meets setup.
- Glitch rejection: a pulse on the synchronised signal shorter than DEBOUNCE_CYCLES cycles never reaches q; its counter returns to 0 when s matches q again.
- Bounce: each return of s to q restarts the count from 0; acceptance requires DEBOUNCE_CYCLES consecutive matching samples.
- sw_changed: asserted in the same cycle sw_clean takes its new value, for exactly one cycle.
  - Several bits accepted in the same cycle give one pulse.
  - Changes accepted in consecutive cycles give consecutive pulses.
- key_press: asserted for one cycle when the debounced key goes 1->0. Release (0->1) gives no pulse.
- mode_pass: see Optional Feature.
  - A key_press and a switch acceptance in the same cycle are both honoured independently.
- Reset mid-count: all progress is discarded. After release, a raw level already held at the pads is re-accepted only after DEBOUNCE_CYCLES+2 edges.
  - A switch held at 1 through reset produces sw_changed on acceptance.
  - A key held pressed through reset produces key_press on acceptance.
- Counters saturate at DEBOUNCE_CYCLES-1 by construction; no wrap-around is possible.

Optional Feature:
- Macro: SWITCH_COND_TOGGLE_EN.
- Defined: mode_pass toggles on every key_press, registered, in the cycle after key_press is high; button release has no effect. Reset value is 1.
- Undefined (momentary): mode_pass equals the debounced key level, registered (pressed = 0 = invert, released = 1 = pass). It changes in the same cycle as the debounced key, and key_press still pulses.
- Port list is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold rst_n=0 with sw_raw=8'hFF, key_raw_n=0 -> all outputs at reset values. Release with inputs held -> sw_clean=8'hFF and sw_changed=1 on edge 6 after release, then sw_changed=0.
- Clean edge: sw_raw 8'h00->8'hA5, held -> sw_clean=8'hA5 on exactly the 6th edge, one sw_changed pulse, no pulse on any other cycle.
- Glitch: sw_raw[3] high for 3 cycles then low -> sw_clean stays 8'h00, sw_changed never asserts.
- Bounce: key_raw_n toggles 1,0,1,0 at 2-cycle intervals, then held 0 -> exactly one key_press, 6 edges after the final 1->0 edge. Release gives no pulse.
- Toggle build: press/release the key twice, each press cleanly -> mode_pass 1->0->1, changing the cycle after each key_press. Momentary build: mode_pass=0 only while the debounced key is 0.
- Async reset mid-count: sw_raw=8'h01 held 3 cycles, rst_n pulsed low between edges -> outputs clear immediately. sw_clean=8'h01 only 6 edges after rst_n release.
